// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: program load into instruction memory, PC boot, branch flush and stall control.
// Latency: every output is registered; state and outputs follow the sampled inputs by one cycle.
// Backpressure: LOAD_READY is high only in LOAD; a loader word transfers on LOAD_VALID & LOAD_READY.
module fetch_controller #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  Clock_in,
   input  logic                  Reset_in,
   input  logic                  LOAD_START,
   input  logic                  RUN_START,
   input  logic                  LOAD_VALID,
   input  logic                  LOAD_LAST,
   input  logic [DATA_WIDTH-1:0] LOAD_DATA,
   output logic                  LOAD_READY,
   output logic                  MEM_INS_SEL_LOAD,
   output logic                  MEM_INS_WE,
   output logic [ADDR_WIDTH-1:0] MEM_INS_ADDRESS,
   output logic [DATA_WIDTH-1:0] MEM_INS_DATA,
   input  logic                  STALL_REQ,
   input  logic                  BRANCH_TAKEN,
   input  logic                  HALT_REQ,
   output logic                  CS_PC_Signal_write,
   output logic                  CS_PC_Signal_reset,
   output logic                  CS_Branch,
   output logic                  IF_FLUSH,
   output logic                  RUNNING,
   output logic [ADDR_WIDTH:0]   LOAD_COUNT,
   output logic [2:0]            STATE
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_BOOT  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_STALL = 3'd4;
   localparam logic [2:0] S_FLUSH = 3'd5;
   localparam logic [2:0] S_HALT  = 3'd6;

   localparam logic [2:0]            FLUSH_INIT = 3'(FLUSH_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = 1;

   logic [2:0]            state_q;
   logic [2:0]            state_nxt;
   logic [2:0]            flush_cnt_q;
   logic [2:0]            flush_cnt_nxt;
   logic [ADDR_WIDTH-1:0] load_addr_q;
   logic                  beat;
   logic                  load_end;
   logic                  branch_nxt;
   logic                  load_entry;

   assign beat       = LOAD_VALID & LOAD_READY;
   // The top address closes the load so the write pointer never wraps.
   assign load_end   = beat & (LOAD_LAST | (load_addr_q == '1));
   assign load_entry = (state_q != S_LOAD) & (state_nxt == S_LOAD);
   assign STATE      = state_q;

   always_comb begin
      state_nxt     = state_q;
      flush_cnt_nxt = flush_cnt_q;
      branch_nxt    = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (LOAD_START) begin
               state_nxt = S_LOAD;
            end else if (RUN_START) begin
               state_nxt = S_BOOT;
            end
         end
         S_LOAD: begin
            if (load_end) begin
               state_nxt = S_BOOT;
            end
         end
         S_BOOT: begin
            state_nxt = S_RUN;
         end
         S_RUN, S_STALL, S_FLUSH: begin
            if (HALT_REQ) begin
               state_nxt = S_HALT;
            end else if (BRANCH_TAKEN) begin
               state_nxt     = S_FLUSH;
               flush_cnt_nxt = FLUSH_INIT;
               branch_nxt    = 1'b1;
            end else if (state_q == S_FLUSH) begin
               flush_cnt_nxt = flush_cnt_q - 3'd1;
               if (flush_cnt_q <= 3'd1) begin
                  state_nxt = S_RUN;
               end
            end else if (STALL_REQ) begin
               state_nxt = S_STALL;
            end else begin
               state_nxt = S_RUN;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock_in) begin
      if (Reset_in) begin
         state_q            <= S_IDLE;
         flush_cnt_q        <= 3'd0;
         load_addr_q        <= '0;
         LOAD_READY         <= 1'b0;
         MEM_INS_SEL_LOAD   <= 1'b0;
         MEM_INS_WE         <= 1'b0;
         MEM_INS_ADDRESS    <= '0;
         MEM_INS_DATA       <= '0;
         CS_PC_Signal_write <= 1'b0;
         CS_PC_Signal_reset <= 1'b1;
         CS_Branch          <= 1'b0;
         IF_FLUSH           <= 1'b0;
         RUNNING            <= 1'b0;
         LOAD_COUNT         <= '0;
      end else begin
         state_q            <= state_nxt;
         flush_cnt_q        <= flush_cnt_nxt;
         LOAD_READY         <= (state_nxt == S_LOAD);
         MEM_INS_WE         <= beat;
         // The mux stays on the load port through the last write, which lands in BOOT.
         MEM_INS_SEL_LOAD   <= (state_nxt == S_LOAD) | beat;
         CS_PC_Signal_write <= (state_nxt == S_RUN) | (state_nxt == S_FLUSH);
         CS_PC_Signal_reset <= (state_nxt == S_IDLE) | (state_nxt == S_BOOT);
         CS_Branch          <= branch_nxt;
         IF_FLUSH           <= (state_nxt == S_FLUSH);
         RUNNING            <= (state_nxt == S_RUN) | (state_nxt == S_STALL) |
                               (state_nxt == S_FLUSH);
         if (load_entry) begin
            load_addr_q <= '0;
            LOAD_COUNT  <= '0;
         end else if (beat) begin
            MEM_INS_ADDRESS <= load_addr_q;
            MEM_INS_DATA    <= LOAD_DATA;
            LOAD_COUNT      <= LOAD_COUNT + CNT_ONE;
            if (!load_end) begin
               load_addr_q <= load_addr_q + ADDR_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a spec-level cycle model checked every cycle,
// plus hand-computed expectations at the points the scenarios call out.
module tb_fetch_controller;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int FC = 2;

   logic          Clock_in;
   logic          Reset_in;
   logic          LOAD_START, RUN_START, LOAD_VALID, LOAD_LAST;
   logic [DW-1:0] LOAD_DATA;
   logic          LOAD_READY, MEM_INS_SEL_LOAD, MEM_INS_WE;
   logic [AW-1:0] MEM_INS_ADDRESS;
   logic [DW-1:0] MEM_INS_DATA;
   logic          STALL_REQ, BRANCH_TAKEN, HALT_REQ;
   logic          CS_PC_Signal_write, CS_PC_Signal_reset, CS_Branch, IF_FLUSH, RUNNING;
   logic [AW:0]   LOAD_COUNT;
   logic [2:0]    STATE;

   fetch_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FLUSH_CYCLES(FC)) dut (
      .Clock_in(Clock_in), .Reset_in(Reset_in),
      .LOAD_START(LOAD_START), .RUN_START(RUN_START),
      .LOAD_VALID(LOAD_VALID), .LOAD_LAST(LOAD_LAST), .LOAD_DATA(LOAD_DATA),
      .LOAD_READY(LOAD_READY), .MEM_INS_SEL_LOAD(MEM_INS_SEL_LOAD),
      .MEM_INS_WE(MEM_INS_WE), .MEM_INS_ADDRESS(MEM_INS_ADDRESS), .MEM_INS_DATA(MEM_INS_DATA),
      .STALL_REQ(STALL_REQ), .BRANCH_TAKEN(BRANCH_TAKEN), .HALT_REQ(HALT_REQ),
      .CS_PC_Signal_write(CS_PC_Signal_write), .CS_PC_Signal_reset(CS_PC_Signal_reset),
      .CS_Branch(CS_Branch), .IF_FLUSH(IF_FLUSH), .RUNNING(RUNNING),
      .LOAD_COUNT(LOAD_COUNT), .STATE(STATE)
   );

   initial Clock_in = 1'b0;
   always #5 Clock_in = ~Clock_in;

   int checks = 0;
   int errors = 0;

   // Output bundle: ready, sel, we, addr, data, write, reset, branch, flush, running, count, state.
   logic [63:0] dut_vec;
   assign dut_vec = {LOAD_READY, MEM_INS_SEL_LOAD, MEM_INS_WE, MEM_INS_ADDRESS, MEM_INS_DATA,
                     CS_PC_Signal_write, CS_PC_Signal_reset, CS_Branch, IF_FLUSH, RUNNING,
                     LOAD_COUNT, STATE};
   localparam logic [63:0] RST_VEC = 64'h0000_0000_0002_0000;

   // Spec-level model: mode holds the documented state code, counters in plain ints.
   int            m_mode = 0;
   int            m_left = 0;
   int            m_next = 0;
   int            m_cnt  = 0;
   bit            m_we   = 0;
   bit            m_br   = 0;
   bit            m_valid = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;

   function automatic logic [63:0] exp_vec();
      return {m_mode == 1, (m_mode == 1) || m_we, m_we, m_addr, m_data,
              (m_mode == 3) || (m_mode == 5), (m_mode == 0) || (m_mode == 2), m_br,
              m_mode == 5, (m_mode >= 3) && (m_mode <= 5), 11'(m_cnt), 3'(m_mode)};
   endfunction

   always @(posedge Clock_in) begin : model
      bit b;
      if (Reset_in) begin
         m_mode = 0; m_left = 0; m_next = 0; m_cnt = 0;
         m_we = 0; m_br = 0; m_addr = '0; m_data = '0;
         m_valid = 1;
      end else if (m_valid) begin
         b    = (m_mode == 1) && LOAD_VALID;
         m_we = b;
         m_br = 0;
         if (b) begin
            m_addr = AW'(m_next);
            m_data = LOAD_DATA;
            m_cnt  = m_cnt + 1;
         end
         if (m_mode == 0 || m_mode == 6) begin
            if (LOAD_START) begin
               m_mode = 1; m_next = 0; m_cnt = 0;
            end else if (RUN_START) begin
               m_mode = 2;
            end
         end else if (m_mode == 1) begin
            if (b && (LOAD_LAST || m_next == (1 << AW) - 1)) m_mode = 2;
            else if (b) m_next = m_next + 1;
         end else if (m_mode == 2) begin
            m_mode = 3;
         end else if (m_mode >= 3 && m_mode <= 5) begin
            if (HALT_REQ) m_mode = 6;
            else if (BRANCH_TAKEN) begin
               m_mode = 5; m_left = FC; m_br = 1;
            end else if (m_mode == 5) begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = 3;
            end else if (STALL_REQ) m_mode = 4;
            else m_mode = 3;
         end else begin
            m_mode = 0;
         end
      end
   end

   always @(negedge Clock_in) begin
      if (m_valid) begin
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
         end
      end
   end

   // Memory image as seen on the write port.
   logic [DW-1:0] cap [0:(1<<AW)-1];
   logic [AW-1:0] wr_q [$];
   always @(negedge Clock_in) begin
      if (MEM_INS_WE === 1'b1) begin
         cap[MEM_INS_ADDRESS] = MEM_INS_DATA;
         wr_q.push_back(MEM_INS_ADDRESS);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge Clock_in);
      #1;
   endtask

   initial begin
      int lowc;
      Reset_in = 1; LOAD_START = 0; RUN_START = 0; LOAD_VALID = 0; LOAD_LAST = 0;
      LOAD_DATA = '0; STALL_REQ = 0; BRANCH_TAKEN = 0; HALT_REQ = 0;
      tick(); tick();
      chk("reset_vec", dut_vec, RST_VEC);
      Reset_in = 0;

      // 4-word load, no gaps
      LOAD_START = 1; tick(); LOAD_START = 0;
      chk("load_state", STATE, 1);
      chk("load_ready", LOAD_READY, 1);
      wr_q.delete();
      for (int i = 0; i < 4; i++) begin
         LOAD_VALID = 1; LOAD_DATA = 32'hA0 + i; LOAD_LAST = (i == 3); tick();
      end
      LOAD_VALID = 0; LOAD_LAST = 0;
      chk("boot_state", STATE, 2);
      chk("final_we", MEM_INS_WE, 1);
      chk("final_addr", MEM_INS_ADDRESS, 3);
      chk("final_sel", MEM_INS_SEL_LOAD, 1);
      chk("boot_pc_reset", CS_PC_Signal_reset, 1);
      chk("ready_drop", LOAD_READY, 0);
      chk("load_count4", LOAD_COUNT, 4);
      tick();
      chk("run_state", STATE, 3);
      chk("run_pc_write", CS_PC_Signal_write, 1);
      chk("run_sel_pc", MEM_INS_SEL_LOAD, 0);
      chk("load4_nwrites", wr_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("load4_data", cap[i], 32'hA0 + i);

      // branch, then a second branch inside FLUSH
      BRANCH_TAKEN = 1; tick(); BRANCH_TAKEN = 0;
      chk("br1_cs", CS_Branch, 1);
      chk("br1_flush", IF_FLUSH, 1);
      tick();
      chk("br1_cs_once", CS_Branch, 0);
      chk("br1_flush2", IF_FLUSH, 1);
      tick();
      chk("br1_back_run", STATE, 3);
      BRANCH_TAKEN = 1; tick(); BRANCH_TAKEN = 0;
      tick();
      BRANCH_TAKEN = 1; tick(); BRANCH_TAKEN = 0;
      chk("rebr_cs", CS_Branch, 1);
      tick();
      chk("rebr_restart", IF_FLUSH, 1);
      tick();
      chk("rebr_run", STATE, 3);

      // plain 3-cycle stall
      lowc = 0;
      for (int i = 0; i < 3; i++) begin
         STALL_REQ = 1; tick();
         if (CS_PC_Signal_write == 1'b0) lowc++;
      end
      STALL_REQ = 0; tick();
      chk("stall3_lowcycles", lowc, 3);
      chk("stall3_run", CS_PC_Signal_write, 1);

      // stall with branch in its second cycle
      STALL_REQ = 1; tick();
      chk("sb_stall_write", CS_PC_Signal_write, 0);
      BRANCH_TAKEN = 1; tick(); BRANCH_TAKEN = 0;
      chk("sb_flush", STATE, 5);
      chk("sb_cs", CS_Branch, 1);
      tick(); STALL_REQ = 0;
      chk("sb_flush2", STATE, 5);
      tick();
      chk("sb_run", STATE, 3);

      // halt beats branch
      HALT_REQ = 1; BRANCH_TAKEN = 1; tick(); HALT_REQ = 0; BRANCH_TAKEN = 0;
      chk("halt_state", STATE, 6);
      chk("halt_no_cs", CS_Branch, 0);
      chk("halt_frozen", CS_PC_Signal_write, 0);
      RUN_START = 1; tick(); RUN_START = 0;
      chk("halt_boot", STATE, 2);
      tick();
      chk("halt_run", STATE, 3);

      // gapped load from HALT
      HALT_REQ = 1; tick(); HALT_REQ = 0;
      LOAD_START = 1; tick(); LOAD_START = 0;
      chk("gap_count_clr", LOAD_COUNT, 0);
      wr_q.delete();
      for (int i = 0; i < 6; i++) begin
         LOAD_VALID = (i % 2 == 0);
         LOAD_DATA  = (i % 2 == 0) ? 32'hB0 + i / 2 : 32'hDEADBEEF;
         LOAD_LAST  = (i == 4);
         tick();
      end
      LOAD_VALID = 0; LOAD_LAST = 0;
      chk("gap_nwrites", wr_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("gap_addr", wr_q[i], i);
         chk("gap_data", cap[i], 32'hB0 + i);
      end
      chk("gap_count", LOAD_COUNT, 3);

      // full-depth load without LAST
      HALT_REQ = 1; tick(); HALT_REQ = 0;
      LOAD_START = 1; tick(); LOAD_START = 0;
      wr_q.delete();
      for (int i = 0; i < 1024; i++) begin
         LOAD_VALID = 1; LOAD_DATA = 32'h1000 + i; tick();
         if (i == 1022) chk("full_still_loading", STATE, 1);
      end
      LOAD_VALID = 0;
      chk("full_boot", STATE, 2);
      chk("full_count", LOAD_COUNT, 1024);
      chk("full_last_addr", MEM_INS_ADDRESS, 1023);
      chk("full_ready_off", LOAD_READY, 0);
      tick();
      chk("full_nwrites", wr_q.size(), 1024);
      chk("full_nowrap", cap[0], 32'h1000);
      chk("full_top_data", cap[1023], 32'h1000 + 1023);

      // reload from HALT, reset after two beats
      HALT_REQ = 1; tick(); HALT_REQ = 0;
      LOAD_START = 1; tick(); LOAD_START = 0;
      LOAD_VALID = 1; LOAD_DATA = 32'hC0; tick();
      chk("reload_addr0", MEM_INS_ADDRESS, 0);
      LOAD_DATA = 32'hC1; tick();
      chk("reload_count2", LOAD_COUNT, 2);
      Reset_in = 1; tick(); Reset_in = 0; LOAD_VALID = 0;
      chk("midload_reset_vec", dut_vec, RST_VEC);
      tick();
      chk("idle_holds", dut_vec, RST_VEC);

      // LOAD_START wins over RUN_START
      LOAD_START = 1; RUN_START = 1; tick(); LOAD_START = 0; RUN_START = 0;
      chk("start_priority", STATE, 1);
      LOAD_VALID = 1; LOAD_LAST = 1; LOAD_DATA = 32'hE0; tick();
      LOAD_VALID = 0; LOAD_LAST = 0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
